// File: rtl/sb_prefetch_ctrl_pkg.sv
// Shared types and geometry helpers for the stream-buffer
// prefetch controller and the stream buffers it manages.
package sb_prefetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_WAIT_FILL,
    S_ISSUE
  } sb_ctrl_state_t;

  function automatic int line_byte_offset(int line_width);
    return $clog2(line_width / 8);
  endfunction

  function automatic int label_width(int line_width);
    return 32 - line_byte_offset(line_width);
  endfunction

  function automatic int page_lbits(int line_width);
    return 12 - line_byte_offset(line_width);
  endfunction

endpackage

// File: rtl/sb_prefetch_ctrl_if.sv
// Cache-side miss request / response channel of the
// stream-buffer prefetch controller.
interface sb_prefetch_ctrl_if #(
  parameter int LABEL_WIDTH = 27,
  parameter int IDX_W       = 2
);

  logic                   miss_req;
  logic [LABEL_WIDTH-1:0] miss_label;
  logic                   miss_rdy;
  logic                   inv;
  logic                   resp_vld;
  logic                   resp_hit;
  logic [IDX_W-1:0]       resp_idx;

  modport master (
    output miss_req,
    output miss_label,
    output inv,
    input  miss_rdy,
    input  resp_vld,
    input  resp_hit,
    input  resp_idx
  );

  modport slave (
    input  miss_req,
    input  miss_label,
    input  inv,
    output miss_rdy,
    output resp_vld,
    output resp_hit,
    output resp_idx
  );

endinterface

// File: rtl/sb_prefetch_ctrl_lookup.sv
// SB_NUM-way label compare with lowest-index priority.
// Purely combinational.
module sb_lookup #(
  parameter int SB_NUM      = 4,
  parameter int LABEL_WIDTH = 27,
  parameter int IDX_W       = $clog2(SB_NUM)
) (
  input  logic [SB_NUM-1:0][LABEL_WIDTH-1:0] label,
  input  logic [SB_NUM-1:0]                  label_vld,
  input  logic [LABEL_WIDTH-1:0]             req_label,
  output logic                               hit,
  output logic [IDX_W-1:0]                   hit_idx
);

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = SB_NUM - 1; i >= 0; i--) begin
      if (label_vld[i] && (label[i] == req_label)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sb_prefetch_ctrl.sv
// Miss lookup across the stream-buffer bank, fill wait,
// response and next-line prefetch scheduling.
module sb_prefetch_ctrl
  import sb_prefetch_ctrl_pkg::*;
#(
  parameter int SB_NUM        = 4,
  parameter int LINE_WIDTH    = 256,
  parameter int DATA_WIDTH    = 32,
  parameter int PAGE_CROSS_EN = 0,
  localparam int WORDS        = LINE_WIDTH / DATA_WIDTH,
  localparam int LABEL_WIDTH  = label_width(LINE_WIDTH),
  localparam int PAGE_LBITS   = page_lbits(LINE_WIDTH),
  localparam int IDX_W        = $clog2(SB_NUM)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  sb_prefetch_ctrl_if.slave                 cache,
  input  logic [SB_NUM-1:0][LABEL_WIDTH-1:0] sb_label_o,
  input  logic [SB_NUM-1:0]                  sb_label_o_vld,
  input  logic [SB_NUM-1:0][WORDS-1:0]       sb_data_vld,
  output logic [SB_NUM-1:0][LABEL_WIDTH-1:0] sb_label_i,
  output logic [SB_NUM-1:0]                  sb_label_i_rdy,
  output logic [SB_NUM-1:0]                  sb_inv,
  output logic [SB_NUM-1:0]                  sb_hit
);

  sb_ctrl_state_t         state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       sel;
  logic [LABEL_WIDTH-1:0] req_label;
  logic                   resp_vld;
  logic                   resp_hit;
  logic [IDX_W-1:0]       resp_idx;

  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic [LABEL_WIDTH-1:0] nxt;
  logic                   page_stop;
  logic                   sel_full;
  logic                   sel_idle;
  logic                   sel_lost;
  logic                   fire;

  sb_lookup #(
    .SB_NUM      (SB_NUM),
    .LABEL_WIDTH (LABEL_WIDTH),
    .IDX_W       (IDX_W)
  ) u_lookup (
    .label     (sb_label_o),
    .label_vld (sb_label_o_vld),
    .req_label (req_label),
    .hit       (hit),
    .hit_idx   (hit_idx)
  );

  assign nxt       = req_label + 1'b1;
  assign page_stop = (PAGE_CROSS_EN == 0) &&
                     (nxt[PAGE_LBITS-1:0] == '0);
  assign sel_full  = &sb_data_vld[sel];
  assign sel_idle  = ~sb_label_o_vld[sel] | sel_full;
  // Buffer got reused or flushed under us while waiting.
  assign sel_lost  = ~sb_label_o_vld[sel] |
                     (sb_label_o[sel] != req_label);
  assign fire      = rst_n & ~cache.inv &
                     (state == S_ISSUE) &
                     ~page_stop & sel_idle;

  assign cache.miss_rdy = (state == S_IDLE) & ~cache.inv;
  assign cache.resp_vld = resp_vld;
  assign cache.resp_hit = resp_hit;
  assign cache.resp_idx = resp_idx;
  assign sb_inv         = {SB_NUM{cache.inv}};

  always_comb begin
    sb_label_i      = '0;
    sb_label_i_rdy  = '0;
    sb_hit          = '0;
    sb_label_i[sel] = nxt;
    if (fire)
      sb_label_i_rdy[sel] = 1'b1;
    if (state == S_WAIT_FILL)
      sb_hit[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      resp_vld  <= 1'b0;
      resp_hit  <= 1'b0;
      resp_idx  <= '0;
      rr_ptr    <= '0;
      req_label <= '0;
      sel       <= '0;
    end else begin
      resp_vld <= 1'b0;
      if (cache.inv) begin
        if ((state == S_LOOKUP) ||
            (state == S_WAIT_FILL)) begin
          resp_vld <= 1'b1;
          resp_hit <= 1'b0;
        end
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (cache.miss_req) begin
              req_label <= cache.miss_label;
              state     <= S_LOOKUP;
            end
          end
          S_LOOKUP: begin
            if (hit) begin
              sel   <= hit_idx;
              state <= S_WAIT_FILL;
            end else begin
              sel      <= rr_ptr;
              rr_ptr   <= rr_ptr + 1'b1;
              resp_vld <= 1'b1;
              resp_hit <= 1'b0;
              state    <= S_ISSUE;
            end
          end
          S_WAIT_FILL: begin
            if (sel_lost) begin
              resp_vld <= 1'b1;
              resp_hit <= 1'b0;
              state    <= S_IDLE;
            end else if (sel_full) begin
              resp_vld <= 1'b1;
              resp_hit <= 1'b1;
              resp_idx <= sel;
              state    <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (page_stop || sel_idle)
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sb_prefetch_ctrl.sv
// Directed bench for sb_prefetch_ctrl; one instance with page
// crossing disabled and one with it enabled share all inputs.
module tb_sb_prefetch_ctrl;

  localparam int N  = 4;
  localparam int LW = 27;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          miss_req = 1'b0;
  logic          inv = 1'b0;
  logic [LW-1:0] miss_label = '0;

  logic [N-1:0][LW-1:0] lbl  = '0;
  logic [N-1:0]         lvld = '0;
  logic [N-1:0][W-1:0]  dvld = '0;

  logic [N-1:0][LW-1:0] label_i0, label_i1;
  logic [N-1:0]         rdy0, rdy1;
  logic [N-1:0]         inv0, inv1;
  logic [N-1:0]         hit0, hit1;

  sb_prefetch_ctrl_if #(.LABEL_WIDTH(LW), .IDX_W(2)) c0 ();
  sb_prefetch_ctrl_if #(.LABEL_WIDTH(LW), .IDX_W(2)) c1 ();

  assign c0.miss_req   = miss_req;
  assign c0.miss_label = miss_label;
  assign c0.inv        = inv;
  assign c1.miss_req   = miss_req;
  assign c1.miss_label = miss_label;
  assign c1.inv        = inv;

  sb_prefetch_ctrl #(
    .SB_NUM(N), .LINE_WIDTH(256),
    .DATA_WIDTH(32), .PAGE_CROSS_EN(0)
  ) dut0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .cache          (c0.slave),
    .sb_label_o     (lbl),
    .sb_label_o_vld (lvld),
    .sb_data_vld    (dvld),
    .sb_label_i     (label_i0),
    .sb_label_i_rdy (rdy0),
    .sb_inv         (inv0),
    .sb_hit         (hit0)
  );

  sb_prefetch_ctrl #(
    .SB_NUM(N), .LINE_WIDTH(256),
    .DATA_WIDTH(32), .PAGE_CROSS_EN(1)
  ) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .cache          (c1.slave),
    .sb_label_o     (lbl),
    .sb_label_o_vld (lvld),
    .sb_data_vld    (dvld),
    .sb_label_i     (label_i1),
    .sb_label_i_rdy (rdy1),
    .sb_inv         (inv1),
    .sb_hit         (hit1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic miss(input logic [LW-1:0] l);
    miss_req   = 1'b1;
    miss_label = l;
    tick();
    miss_req   = 1'b0;
  endtask

  initial begin
    int v;
    logic [LW-1:0] ml;

    // reset
    tick();
    tick();
    check("rst_vld", c0.resp_vld, 0);
    check("rst_hit", c0.resp_hit, 0);
    check("rst_idx", c0.resp_idx, 0);
    check("rst_rdy", rdy0, 0);
    check("rst_sbhit", hit0, 0);
    check("rst_missrdy", c0.miss_rdy, 1);
    rst_n = 1'b1;

    // cold miss
    miss(27'h100);
    check("t1_missrdy_busy", c0.miss_rdy, 0);
    check("t1_vld_t1", c0.resp_vld, 0);
    tick();
    check("t1_vld", c0.resp_vld, 1);
    check("t1_hit", c0.resp_hit, 0);
    check("t1_rdy", rdy0, 4'b0001);
    check("t1_lbl", label_i0[0], 27'h101);
    tick();
    check("t1_vld_off", c0.resp_vld, 0);
    check("t1_rdy_off", rdy0, 0);
    check("t1_missrdy", c0.miss_rdy, 1);

    // hit while filling
    lbl[2]  = 27'h101;
    lvld    = 4'b0100;
    dvld[2] = 8'h0F;
    miss(27'h101);
    tick();
    check("t2_sbhit", hit0, 4'b0100);
    check("t2_vld_wait", c0.resp_vld, 0);
    tick();
    check("t2_vld_wait2", c0.resp_vld, 0);
    check("t2_sbhit2", hit0, 4'b0100);
    dvld[2] = 8'hFF;
    tick();
    check("t2_vld", c0.resp_vld, 1);
    check("t2_hit", c0.resp_hit, 1);
    check("t2_idx", c0.resp_idx, 2);
    check("t2_rdy", rdy0, 4'b0100);
    check("t2_lbl", label_i0[2], 27'h102);
    check("t2_lane0", label_i0[0], 0);
    check("t2_sbhit_off", hit0, 0);
    tick();
    check("t2_rdy_off", rdy0, 0);

    // page boundary, victim 1
    lbl  = '0;
    lvld = '0;
    dvld = '0;
    miss(27'h17F);
    tick();
    check("t3_vld", c0.resp_vld, 1);
    check("t3_hit", c0.resp_hit, 0);
    check("t3_idx_held", c0.resp_idx, 2);
    check("t3_rdy_nocross", rdy0, 0);
    check("t3_vld_cross", c1.resp_vld, 1);
    check("t3_rdy_cross", rdy1, 4'b0010);
    check("t3_lbl_cross", label_i1[1], 27'h180);
    tick();
    check("t3_idle0", c0.miss_rdy, 1);
    check("t3_idle1", c1.miss_rdy, 1);

    // label wrap, victim 2
    miss(27'h7FFFFFF);
    tick();
    check("t4_rdy_cross", rdy1, 4'b0100);
    check("t4_lbl_cross", label_i1[2], 0);
    check("t4_rdy_nocross", rdy0, 0);
    tick();

    // inv while waiting on buffer 3
    lbl[3]  = 27'h200;
    lvld    = 4'b1000;
    dvld[3] = 8'h01;
    miss(27'h200);
    tick();
    check("t5_sbhit", hit0, 4'b1000);
    inv        = 1'b1;
    miss_req   = 1'b1;
    miss_label = 27'h300;
    #1;
    check("t5_missrdy_inv", c0.miss_rdy, 0);
    check("t5_sbinv", inv0, 4'b1111);
    tick();
    check("t5_vld", c0.resp_vld, 1);
    check("t5_hit", c0.resp_hit, 0);
    check("t5_idx", c0.resp_idx, 2);
    check("t5_rdy", rdy0, 0);
    inv      = 1'b0;
    miss_req = 1'b0;
    #1;
    check("t5_idle", c0.miss_rdy, 1);
    check("t5_sbhit_off", hit0, 0);
    check("t5_sbinv_off", inv0, 0);
    tick();
    check("t5_vld_off", c0.resp_vld, 0);
    check("t5_noaccept", c0.miss_rdy, 1);

    // round robin over busy buffers, pointer is at 3
    lbl[0] = 27'h10;
    lbl[1] = 27'h20;
    lbl[2] = 27'h30;
    lbl[3] = 27'h40;
    lvld   = 4'b1111;
    dvld   = '0;
    for (int k = 0; k < 4; k++) begin
      v  = (3 + k) % 4;
      ml = 27'h500 + LW'(k * 16);
      miss(ml);
      tick();
      check("t6_vld", c0.resp_vld, 1);
      check("t6_hit", c0.resp_hit, 0);
      check("t6_rdy_busy", rdy0, 0);
      tick();
      check("t6_rdy_wait", rdy0, 0);
      dvld[v] = 8'hFF;
      #1;
      check("t6_rdy", rdy0, 32'(1) << v);
      check("t6_lbl", label_i0[v], ml + 1);
      tick();
      check("t6_rdy_off", rdy0, 0);
      dvld[v] = '0;
    end

    // reset while waiting to issue into buffer 3
    miss(27'h540);
    tick();
    check("t6_vld5", c0.resp_vld, 1);
    rst_n   = 1'b0;
    dvld[3] = 8'hFF;
    #1;
    check("t6_rst_rdy", rdy0, 0);
    tick();
    check("t6_rst_vld", c0.resp_vld, 0);
    check("t6_rst_hit", c0.resp_hit, 0);
    check("t6_rst_idx", c0.resp_idx, 0);
    check("t6_rst_rdy2", rdy0, 0);
    check("t6_rst_sbhit", hit0, 0);
    check("t6_rst_missrdy", c0.miss_rdy, 1);
    rst_n = 1'b1;
    lvld  = '0;
    dvld  = '0;

    // pointer restarts at 0
    miss(27'h600);
    tick();
    check("t7_rdy", rdy0, 4'b0001);
    check("t7_lbl", label_i0[0], 27'h601);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
